key_input_ctrl: RTL and testbench
=================================

# key_input_ctrl

Decodes the PS/2 keyboard byte stream into game controls for the two players, Jerry (WASD) and Tom (arrow keys). It sits between the PS/2 receiver (16-bit keycode plus per-byte strobe) and the game logic. Its jobs:
- sequence the make, break and extended-prefix protocol with an FSM;
- track which keys are held;
- arbitrate opposing directions per player;
- emit start and pause events.

## Interface
Parameters:
- TIMEOUT_CYC, 1_000_000: cycles without a byte, while a prefix is pending, before the FSM abandons the sequence (20 ms at 50 MHz).
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK50MHZ  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- keycode  in  16  {previous byte, current byte} from the receiver; only [7:0] is decoded.
- key_valid  in  1  one-cycle strobe: keycode[7:0] holds a newly received byte.
- held  out  8  raw held-key bitmap {Tom R,L,D,U, Jerry R,L,D,U}.
- jerry_dir  out  4  resolved {up,down,left,right}; at most one bit per axis.
- tom_dir  out  4  resolved {up,down,left,right}; at most one bit per axis.
- start_pulse  out  1  one-cycle pulse on a Space make.
- paused  out  1  level; toggles on each Esc make.
- seq_err  out  1  one-cycle pulse when a pending prefix times out.

## Operation
Scan codes (set 2):
- Jerry: W 1D, A 1C, S 1B, D 23.
- Tom: E0-prefixed 75 up, 6B left, 72 down, 74 right.
- Space 29, Esc 76.
- Prefixes: E0 extended, F0 break.

FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on key_valid by byte value:
- F0: IDLE goes to BRK. EXT goes to EXT_BRK. BRK and EXT_BRK stay put.
- E0: any state goes to EXT. A partial sequence is discarded.
- Any other byte is a terminal code. It is applied, then the FSM returns to IDLE:
  - IDLE is a normal make;
  - EXT is an extended make;
  - BRK is a normal break;
  - EXT_BRK is an extended break.

Applying a terminal code:
- The code matches only with the correct extended-ness. A non-extended 75 (keypad 8) is not Tom up. An extended 1D is not W.
- Unmapped codes are consumed with no effect.
- A make sets the held bit. A break clears it.
- A make for an already-held key (typematic repeat) changes nothing, including arbitration history.
- A break for a key that is not held changes nothing.
- Space and Esc are not in `held`. Their breaks are ignored. Repeats also fire the event, because Space and Esc are not tracked in `held`.

Axis arbitration (4 independent axes: Jerry V, Jerry H, Tom V, Tom H):
- Each axis keeps a `last` bit recording which of its two keys had the most recent non-repeat make.
- One key held: that direction.
- Both held: the `last` key wins.
- Neither held: 0.
- Releasing the winner while the loser is still held switches the output to the loser.

Timeout:
- The counter resets on every key_valid and in IDLE.
- In any non-IDLE state it increments each cycle.
- On reaching TIMEOUT_CYC-1: the FSM goes to IDLE and seq_err pulses for one cycle.
- key_valid in the expiry cycle takes priority. The byte is processed in the current state and no seq_err is raised.

Reset values: held=0, jerry_dir=0, tom_dir=0, start_pulse=0, paused=0, seq_err=0, FSM=IDLE, counter=0, all `last` bits=0.

## Timing
- All outputs are registered.
- key_valid in cycle N → held, start_pulse and paused update at edge N+1.
- jerry_dir and tom_dir update at edge N+2, registered from held and `last`.
- seq_err asserts at the edge after the counter hits TIMEOUT_CYC-1.
- Back-to-back key_valid on consecutive cycles must be handled; no stall, no ready signal.
- rst has priority over key_valid and the timeout. Reset mid-sequence discards the prefix state. Keys held at reset read as released until their next make.

## Structure
- Package kbd_pkg:
  - scan-code localparams (SC_W, SC_A, SC_S, SC_D, SC_UP, SC_LEFT, SC_DOWN, SC_RIGHT, SC_SPACE, SC_ESC, SC_E0, SC_F0);
  - held-bit index constants;
  - FSM state encoding.
- Sub-module axis_arbiter (inputs: clk, rst, key_a/key_b held bits, make_a/make_b pulses; output: 2-bit one-hot direction). Instantiated 4×.
- Top level holds the FSM, timeout counter, held register, and event logic.

## Test plan
- Jerry arbitration: 1C; then 23; then F0,23 → jerry_dir 0010 → 0001 → 0010. held bits track each step.
- Tom extended make/break: E0,75 sets Tom up and tom_dir=1000. A bare 75 has no effect. E0,F0,75 clears Tom up.
- Repeats: 1D,1D,1D,1B then F0,1B → held shows W and S, jerry_dir=0100 (S was last). After the S break, jerry_dir=1000.
- Start and pause: 29 → start_pulse high for exactly 1 cycle. 76,F0,76,76 → paused goes 0→1→0.
- Prefix timeout: E0 then silence → seq_err at cycle TIMEOUT_CYC (small TIMEOUT_CYC in sim). A following 75 is treated as a non-extended make (no effect).
- Reset mid-operation: hold 1C and E0,6B; assert rst while F0 is pending → all outputs 0, FSM=IDLE. A following 6B has no effect.

Source files
------------

// File: rtl/kbd_pkg.sv
// Scan codes, held-bitmap layout and FSM encoding shared by the PS/2 key decoder.
package kbd_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Held bitmap: {Tom R,L,D,U, Jerry R,L,D,U}
    localparam logic [2:0] HB_J_UP    = 3'd0;
    localparam logic [2:0] HB_J_DOWN  = 3'd1;
    localparam logic [2:0] HB_J_LEFT  = 3'd2;
    localparam logic [2:0] HB_J_RIGHT = 3'd3;
    localparam logic [2:0] HB_T_UP    = 3'd4;
    localparam logic [2:0] HB_T_DOWN  = 3'd5;
    localparam logic [2:0] HB_T_LEFT  = 3'd6;
    localparam logic [2:0] HB_T_RIGHT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Extended-ness must match: bare 75 is keypad 8, E0 1D is not W.
    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = HB_J_UP;
        if (!ext) begin
            case (code)
                SC_W:    m.idx = HB_J_UP;
                SC_S:    m.idx = HB_J_DOWN;
                SC_A:    m.idx = HB_J_LEFT;
                SC_D:    m.idx = HB_J_RIGHT;
                default: m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    m.idx = HB_T_UP;
                SC_DOWN:  m.idx = HB_T_DOWN;
                SC_LEFT:  m.idx = HB_T_LEFT;
                SC_RIGHT: m.idx = HB_T_RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_arbiter.sv
// Resolves two opposing keys on one axis to a one-hot {a,b} direction; most recent make wins.
// Registered output, one cycle after the held bits; no backpressure.
module axis_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_a,
    input  logic       key_b,
    input  logic       make_a,
    input  logic       make_b,
    output logic [1:0] dir
);

    logic       last;
    logic [1:0] dir_next;

    always_comb begin
        dir_next = 2'b00;
        case ({key_a, key_b})
            2'b10:   dir_next = 2'b10;
            2'b01:   dir_next = 2'b01;
            2'b11:   dir_next = last ? 2'b01 : 2'b10;
            default: dir_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b0;
            dir  <= 2'b00;
        end else begin
            if (make_b)
                last <= 1'b1;
            else if (make_a)
                last <= 1'b0;
            dir <= dir_next;
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// PS/2 byte stream to player controls: held/events one cycle after key_valid, directions two.
// Accepts a byte every cycle; there is no backpressure.
module key_input_ctrl
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic        CLK50MHZ,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        key_valid,
    output logic [7:0]  held,
    output logic [3:0]  jerry_dir,
    output logic [3:0]  tom_dir,
    output logic        start_pulse,
    output logic        paused,
    output logic        seq_err
);

    kbd_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       code;
    logic             is_ext, is_brk, terminal, expired;
    key_map_t         km;
    logic [7:0]       held_next;
    logic [7:0]       make_vec;
    logic             start_next, esc_make;

    logic unused_prev_byte;
    assign unused_prev_byte = ^keycode[15:8];

    assign code     = keycode[7:0];
    assign is_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign is_brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign terminal = key_valid && (code != SC_E0) && (code != SC_F0);
    assign expired  = (state != ST_IDLE) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign km       = map_key(code, is_ext);

    always_comb begin
        state_next = state;
        if (key_valid) begin
            if (code == SC_F0) begin
                case (state)
                    ST_IDLE: state_next = ST_BRK;
                    ST_EXT:  state_next = ST_EXT_BRK;
                    default: state_next = state;
                endcase
            end else if (code == SC_E0) begin
                state_next = ST_EXT;
            end else begin
                state_next = ST_IDLE;
            end
        end else if (expired) begin
            state_next = ST_IDLE;
        end
    end

    // Repeats and breaks of unheld keys leave both held and arbitration history alone.
    always_comb begin
        held_next  = held;
        make_vec   = 8'h00;
        start_next = 1'b0;
        esc_make   = 1'b0;
        if (terminal) begin
            if (km.hit) begin
                if (is_brk) begin
                    held_next[km.idx] = 1'b0;
                end else if (!held[km.idx]) begin
                    held_next[km.idx] = 1'b1;
                    make_vec[km.idx]  = 1'b1;
                end
            end
            if (!is_ext && !is_brk) begin
                start_next = (code == SC_SPACE);
                esc_make   = (code == SC_ESC);
            end
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            held        <= 8'h00;
            start_pulse <= 1'b0;
            paused      <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_next;
            held        <= held_next;
            start_pulse <= start_next;
            seq_err     <= expired && !key_valid;
            if (esc_make)
                paused <= !paused;
            if (key_valid || state == ST_IDLE || expired)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    axis_arbiter u_jerry_v (
        .clk(CLK50MHZ), .rst(rst),
        .key_a(held[HB_J_UP]), .key_b(held[HB_J_DOWN]),
        .make_a(make_vec[HB_J_UP]), .make_b(make_vec[HB_J_DOWN]),
        .dir(jerry_dir[3:2])
    );

    axis_arbiter u_jerry_h (
        .clk(CLK50MHZ), .rst(rst),
        .key_a(held[HB_J_LEFT]), .key_b(held[HB_J_RIGHT]),
        .make_a(make_vec[HB_J_LEFT]), .make_b(make_vec[HB_J_RIGHT]),
        .dir(jerry_dir[1:0])
    );

    axis_arbiter u_tom_v (
        .clk(CLK50MHZ), .rst(rst),
        .key_a(held[HB_T_UP]), .key_b(held[HB_T_DOWN]),
        .make_a(make_vec[HB_T_UP]), .make_b(make_vec[HB_T_DOWN]),
        .dir(tom_dir[3:2])
    );

    axis_arbiter u_tom_h (
        .clk(CLK50MHZ), .rst(rst),
        .key_a(held[HB_T_LEFT]), .key_b(held[HB_T_RIGHT]),
        .make_a(make_vec[HB_T_LEFT]), .make_b(make_vec[HB_T_RIGHT]),
        .dir(tom_dir[1:0])
    );

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl: byte table plus hand sequences for events, timeout and reset.
module tb_key_input_ctrl;

    localparam int T = 16;

    logic        CLK50MHZ = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        key_valid;
    logic [7:0]  held;
    logic [3:0]  jerry_dir;
    logic [3:0]  tom_dir;
    logic        start_pulse;
    logic        paused;
    logic        seq_err;

    key_input_ctrl #(.TIMEOUT_CYC(T), .CNT_W(5)) dut (
        .CLK50MHZ(CLK50MHZ),
        .rst(rst),
        .keycode(keycode),
        .key_valid(key_valid),
        .held(held),
        .jerry_dir(jerry_dir),
        .tom_dir(tom_dir),
        .start_pulse(start_pulse),
        .paused(paused),
        .seq_err(seq_err)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    typedef struct {
        logic [7:0] b;
        logic [7:0] held;
        logic [3:0] jd;
        logic [3:0] td;
        logic       pz;
    } vec_t;

    vec_t       vecs[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] prev = 8'h00;

    function automatic vec_t mk(input logic [7:0] b, input logic [7:0] h,
                                input logic [3:0] jd, input logic [3:0] td, input logic pz);
        vec_t v;
        v.b = b; v.held = h; v.jd = jd; v.td = td; v.pz = pz;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Returns at the negedge after the capturing edge: held/events are visible here.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK50MHZ);
        keycode   = {prev, b};
        key_valid = 1'b1;
        prev      = b;
        @(negedge CLK50MHZ);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK50MHZ);
    endtask

    initial begin
        rst       = 1'b1;
        keycode   = 16'h0000;
        key_valid = 1'b0;

        // Byte, then expected held / jerry_dir / tom_dir / paused once directions settle
        vecs.push_back(mk(8'h1C, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h23, 8'h0C, 4'b0001, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h0C, 4'b0001, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h23, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1C, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h75, 8'h10, 4'b0000, 4'b1000, 1'b0));
        vecs.push_back(mk(8'h75, 8'h10, 4'b0000, 4'b1000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h10, 4'b0000, 4'b1000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h10, 4'b0000, 4'b1000, 1'b0));
        vecs.push_back(mk(8'h75, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1D, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1D, 8'h01, 4'b1000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1D, 8'h01, 4'b1000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1D, 8'h01, 4'b1000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1B, 8'h03, 4'b0100, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h03, 4'b0100, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1B, 8'h01, 4'b1000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h01, 4'b1000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1D, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h23, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h76, 8'h00, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(8'hF0, 8'h00, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(8'h76, 8'h00, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(8'h76, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h76, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h6B, 8'h40, 4'b0000, 4'b0010, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h40, 4'b0000, 4'b0010, 1'b0));
        vecs.push_back(mk(8'h74, 8'hC0, 4'b0000, 4'b0001, 1'b0));
        vecs.push_back(mk(8'hE0, 8'hC0, 4'b0000, 4'b0001, 1'b0));
        vecs.push_back(mk(8'hF0, 8'hC0, 4'b0000, 4'b0001, 1'b0));
        vecs.push_back(mk(8'h74, 8'h40, 4'b0000, 4'b0010, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h40, 4'b0000, 4'b0010, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h40, 4'b0000, 4'b0010, 1'b0));
        vecs.push_back(mk(8'h6B, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h72, 8'h20, 4'b0000, 4'b0100, 1'b0));
        vecs.push_back(mk(8'hE0, 8'h20, 4'b0000, 4'b0100, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h20, 4'b0000, 4'b0100, 1'b0));
        vecs.push_back(mk(8'h72, 8'h00, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1C, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'hF0, 8'h04, 4'b0010, 4'b0000, 1'b0));
        vecs.push_back(mk(8'h1C, 8'h00, 4'b0000, 4'b0000, 1'b0));

        idle(3);
        rst = 1'b0;
        check("reset held", held, 8'h00);
        check("reset jerry_dir", {4'h0, jerry_dir}, 8'h00);
        check("reset tom_dir", {4'h0, tom_dir}, 8'h00);
        check("reset start_pulse", {7'h0, start_pulse}, 8'h00);
        check("reset paused", {7'h0, paused}, 8'h00);
        check("reset seq_err", {7'h0, seq_err}, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].b);
            @(negedge CLK50MHZ);
            check($sformatf("vec%0d held", i), held, vecs[i].held);
            check($sformatf("vec%0d jerry_dir", i), {4'h0, jerry_dir}, {4'h0, vecs[i].jd});
            check($sformatf("vec%0d tom_dir", i), {4'h0, tom_dir}, {4'h0, vecs[i].td});
            check($sformatf("vec%0d paused", i), {7'h0, paused}, {7'h0, vecs[i].pz});
        end

        // Space: exactly one cycle per make, repeats fire, break does not
        for (int r = 0; r < 2; r++) begin
            send_byte(8'h29);
            check($sformatf("space%0d start high", r), {7'h0, start_pulse}, 8'h01);
            @(negedge CLK50MHZ);
            check($sformatf("space%0d start low", r), {7'h0, start_pulse}, 8'h00);
        end
        send_byte(8'hF0);
        send_byte(8'h29);
        check("space break start", {7'h0, start_pulse}, 8'h00);
        send_byte(8'hE0);
        send_byte(8'h29);
        check("ext space start", {7'h0, start_pulse}, 8'h00);

        // Prefix timeout: seq_err only after T-th edge, then the prefix is gone
        send_byte(8'hE0);
        for (int k = 1; k <= T + 1; k++) begin
            @(negedge CLK50MHZ);
            check($sformatf("timeout edge%0d seq_err", k), {7'h0, seq_err}, (k == T) ? 8'h01 : 8'h00);
        end
        send_byte(8'h75);
        idle(1);
        check("after timeout held", held, 8'h00);
        check("after timeout tom_dir", {4'h0, tom_dir}, 8'h00);

        // A byte landing in the expiry cycle wins over the timeout
        send_byte(8'hE0);
        idle(T - 2);
        send_byte(8'h75);
        check("expiry-cycle byte held", held, 8'h10);
        check("expiry-cycle seq_err", {7'h0, seq_err}, 8'h00);
        @(negedge CLK50MHZ);
        check("expiry-cycle seq_err late", {7'h0, seq_err}, 8'h00);
        check("expiry-cycle tom_dir", {4'h0, tom_dir}, 8'h08);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        idle(1);
        check("tom up release", held, 8'h00);

        // Reset mid-sequence with keys held and paused set
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'h76);
        idle(1);
        check("pre-reset held", held, 8'h44);
        check("pre-reset paused", {7'h0, paused}, 8'h01);
        send_byte(8'hF0);
        @(negedge CLK50MHZ);
        rst = 1'b1;
        @(negedge CLK50MHZ);
        rst = 1'b0;
        check("mid reset held", held, 8'h00);
        check("mid reset jerry_dir", {4'h0, jerry_dir}, 8'h00);
        check("mid reset tom_dir", {4'h0, tom_dir}, 8'h00);
        check("mid reset paused", {7'h0, paused}, 8'h00);
        check("mid reset seq_err", {7'h0, seq_err}, 8'h00);
        send_byte(8'h6B);
        idle(1);
        check("post reset 6B held", held, 8'h00);
        check("post reset 6B tom_dir", {4'h0, tom_dir}, 8'h00);
        send_byte(8'h1C);
        idle(1);
        check("post reset 1C held", held, 8'h04);
        check("post reset 1C jerry_dir", {4'h0, jerry_dir}, 8'h02);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
